mat_vec_product: RTL
====================

# mat_vec_product

Parametrised fixed-point matrix-vector multiplier: computes ROWS dot products of a captured ROWS×VECTOR_LEN matrix against a captured VECTOR_LEN vector. It uses LANES parallel multipliers and emits one rounded, saturated result per row over a valid/ready stream. It is the successor to the single dot-product unit and is the building block for dense ANN layers.

## Interface
- VECTOR_LEN, 4, elements per row; must be a multiple of LANES
- ROWS, 4, matrix rows = number of results per job
- LANES, 2, multiplies per cycle
- DATA_W, 16, signed fixed-point element/result width
- FRAC_W, 8, fractional bits of elements and result (Q(DATA_W-FRAC_W).FRAC_W)
- ACC_W, 40, signed accumulator width; must be ≥ 2·DATA_W + clog2(VECTOR_LEN)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- mat_in  in  ROWS·VECTOR_LEN·DATA_W  flattened matrix; element [r][i] at bit offset (r·VECTOR_LEN+i)·DATA_W
- vec_in  in  VECTOR_LEN·DATA_W  flattened vector; element i at bit offset i·DATA_W
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  signed result for row out_row
- out_row  out  max(1,clog2(ROWS))  row index of out_data
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE, RUN, EMIT, DONE.
- IDLE: start=1 at an edge latches mat_in and vec_in into internal registers, clears the accumulator, sets row=0, chunk=0, and goes to RUN. Inputs may change afterwards.
- RUN: each cycle adds the sum of LANES products (mat[row][chunk·LANES+k]·vec[chunk·LANES+k], full 2·DATA_W signed) to the accumulator. Increments chunk. After chunk K-1, where K=VECTOR_LEN/LANES, goes to EMIT.
- EMIT: out_valid=1. out_data = sat(round(acc)), with round = (acc + 2^(FRAC_W-1)) >>> FRAC_W (round half up) and sat clamping to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- EMIT exit: on out_valid & out_ready, if row<ROWS-1, increments row, clears the accumulator and chunk, and returns to RUN. Otherwise goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- out_data and out_row hold stable while out_valid=1 and out_ready=0. Both are 0 when out_valid=0.
- start is ignored outside IDLE, including in the DONE cycle.
- The accumulator cannot overflow given the ACC_W constraint. Saturation applies only at output.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, out_row=0, done=0, state=IDLE. All internal registers are cleared.
- rst asserted mid-job aborts immediately (async). The pending result is discarded and no done is issued. After release, the block waits in IDLE for a new start.
- start sampled at edge 0: RUN occupies cycles 1..K and first out_valid appears in cycle K+1.
- With out_ready held high, each row takes K+1 cycles. done is asserted in cycle ROWS·(K+1)+1 after the start edge.
- Each cycle of out_ready=0 in EMIT adds one cycle of latency. Nothing is lost or duplicated.
- out_ready may be high before out_valid; acceptance requires both high at the same edge.

## Configuration
- MVP_RELU_EN defined: after saturation, negative results are replaced by 0 (ReLU). Row indexing and timing are unchanged.
- MVP_RELU_EN undefined: signed saturated results are output unchanged.

## Structure
- Shared package mvp_pkg holds:
  - the state enum (IDLE, RUN, EMIT, DONE)
  - the sat/round function, parametrised by width
  - derived constants K and the row/chunk counter widths
- Sub-module mvp_lane_sum: combinational; LANES signed multipliers plus an adder tree producing a sign-extended ACC_W partial sum. The FSM, counters, accumulator and output register live in mat_vec_product.
- Elaboration assertions enforce VECTOR_LEN % LANES == 0 and the ACC_W bound.

## Test plan
All values use defaults (Q8.8, 1.0 = 256).
- Basic: vec all 1.0, row0={2,1,1,1}, rows1–3 identity rows, out_ready=1. Expect out_data 1280 (5.0), then 256 ×3, out_row 0..3, out_valid each K+1=3 cycles, done at cycle 13.
- Rounding: vec[0]=128 (0.5), row0[0]=1 (1/256), other elements 0. Expect out_data=1. With row0[0]=-1, expect 0 (half up).
- Saturation: all elements 100.0 (25600). Expect 32767 per row. With matrix -100.0, expect -32768, or 0 when MVP_RELU_EN is defined.
- Backpressure: out_ready low for 5 cycles at row 1. Expect out_valid, out_data and out_row held stable, exactly 4 results, done delayed by 5 cycles.
- Reset mid-job: assert rst in RUN of row 2. Expect all outputs 0 within the same cycle and no done. A new start then yields a full 4-row result set.
- Start while busy: pulse start with different inputs during RUN and in the DONE cycle. Expect both ignored and the original results unchanged.

Source files
------------

// File: rtl/mvp_pkg.sv
// Shared types and helpers for mat_vec_product: FSM state encoding, counter sizing
// and the round-half-up / saturate function applied to accumulator results.
package mvp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EMIT,
        DONE
    } state_e;

    // Working width of the rounding helper; accumulators are sign-extended into it.
    localparam int SAT_MAX_W = 64;
    localparam logic signed [SAT_MAX_W-1:0] SAT_ONE = 1;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int chunks(input int vector_len, input int lanes);
        return vector_len / lanes;
    endfunction

    // Round half up at frac_w, then clamp to the signed data_w range.
    function automatic logic signed [SAT_MAX_W-1:0] round_sat(
        input logic signed [SAT_MAX_W-1:0] acc,
        input int                          data_w,
        input int                          frac_w
    );
        logic signed [SAT_MAX_W-1:0] half;
        logic signed [SAT_MAX_W-1:0] rnd;
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        if (frac_w > 0) half = SAT_ONE <<< (frac_w - 1);
        else            half = '0;
        rnd = (acc + half) >>> frac_w;
        hi  = (SAT_ONE <<< (data_w - 1)) - SAT_ONE;
        lo  = -hi - SAT_ONE;
        if (rnd > hi)      return hi;
        else if (rnd < lo) return lo;
        else               return rnd;
    endfunction

endpackage

// File: rtl/mat_vec_product_if.sv
// Result stream of mat_vec_product: valid/ready handshake carrying one signed
// result and its row index per transfer.
interface mat_vec_product_if #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 2
);
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]         out_row;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        output out_ready
    );
endinterface

// File: rtl/mvp_lane_sum.sv
// Combinational lane datapath: LANES signed DATA_W x DATA_W multiplies reduced by a
// balanced adder tree into a sign-extended ACC_W partial sum.
module mvp_lane_sum #(
    parameter int LANES  = 2,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic [LANES*DATA_W-1:0] a_flat,
    input  logic [LANES*DATA_W-1:0] b_flat,
    output logic signed [ACC_W-1:0] sum
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int LEAVES = 1 << $clog2(LANES);

    logic signed [PROD_W-1:0] a_ext [LANES];
    logic signed [PROD_W-1:0] b_ext [LANES];
    logic signed [PROD_W-1:0] prod  [LANES];
    // Heap-ordered tree: node i sums nodes 2i and 2i+1, leaves start at LEAVES.
    logic signed [ACC_W-1:0]  node  [1:2*LEAVES-1];

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_ext[k] = PROD_W'($signed(a_flat[k*DATA_W +: DATA_W]));
            b_ext[k] = PROD_W'($signed(b_flat[k*DATA_W +: DATA_W]));
            prod[k]  = a_ext[k] * b_ext[k];
        end
    end

    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            if (i < LANES) node[LEAVES + i] = ACC_W'(prod[i]);
            else           node[LEAVES + i] = '0;
        end
        for (int i = LEAVES - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i + 1];
        end
        sum = node[1];
    end

endmodule

// File: rtl/mat_vec_product.sv
// Fixed-point matrix-vector multiplier: LANES products per cycle, one rounded and
// saturated result per row on a valid/ready stream. Define MVP_RELU_EN to clamp negatives to 0.
module mat_vec_product
    import mvp_pkg::*;
#(
    parameter int VECTOR_LEN = 4,
    parameter int ROWS       = 4,
    parameter int LANES      = 2,
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int ACC_W      = 40
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROWS*VECTOR_LEN*DATA_W-1:0] mat_in,
    input  logic [VECTOR_LEN*DATA_W-1:0]      vec_in,
    output logic                              busy,
    output logic                              done,
    mat_vec_product_if.master                 out_if
);

    localparam int K       = chunks(VECTOR_LEN, LANES);
    localparam int ROW_W   = cnt_w(ROWS);
    localparam int CHUNK_W = cnt_w(K);
    localparam int MAT_W   = ROWS * VECTOR_LEN * DATA_W;
    localparam int VEC_W   = VECTOR_LEN * DATA_W;

    generate
        if (VECTOR_LEN % LANES != 0) begin : g_bad_lanes
            $fatal(1, "mat_vec_product: VECTOR_LEN must be a multiple of LANES");
        end
        if (ACC_W < 2 * DATA_W + $clog2(VECTOR_LEN) || ACC_W >= SAT_MAX_W) begin : g_bad_acc
            $fatal(1, "mat_vec_product: ACC_W out of range");
        end
    endgenerate

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [CHUNK_W-1:0]       chunk_q, chunk_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [MAT_W-1:0]         mat_q, mat_d;
    logic [VEC_W-1:0]         vec_q, vec_d;

    logic [LANES*DATA_W-1:0]  lane_a;
    logic [LANES*DATA_W-1:0]  lane_b;
    logic signed [ACC_W-1:0]  lane_sum;
    logic signed [DATA_W-1:0] result;

    // Operands for the current row and chunk, taken from the captured copies.
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_a[k*DATA_W +: DATA_W] =
                mat_q[(int'(row_q) * VECTOR_LEN + int'(chunk_q) * LANES + k) * DATA_W +: DATA_W];
            lane_b[k*DATA_W +: DATA_W] =
                vec_q[(int'(chunk_q) * LANES + k) * DATA_W +: DATA_W];
        end
    end

    mvp_lane_sum #(
        .LANES  (LANES),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane_sum (
        .a_flat (lane_a),
        .b_flat (lane_b),
        .sum    (lane_sum)
    );

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        chunk_d = chunk_q;
        acc_d   = acc_q;
        mat_d   = mat_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mat_d   = mat_in;
                    vec_d   = vec_in;
                    acc_d   = '0;
                    row_d   = '0;
                    chunk_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + lane_sum;
                if (chunk_q == CHUNK_W'(K - 1)) state_d = EMIT;
                else                            chunk_d = chunk_q + CHUNK_W'(1);
            end
            EMIT: begin
                if (out_if.out_ready) begin
                    if (row_q != ROW_W'(ROWS - 1)) begin
                        row_d   = row_q + ROW_W'(1);
                        acc_d   = '0;
                        chunk_d = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the captured
    // operand registers are cleared on reset too so an aborted job leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            chunk_q <= '0;
            acc_q   <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            chunk_q <= chunk_d;
            acc_q   <= acc_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
        end
    end

    // The accumulator holds through EMIT, so the result is formed directly from it.
    always_comb begin
        result = DATA_W'(round_sat(SAT_MAX_W'(acc_q), DATA_W, FRAC_W));
`ifdef MVP_RELU_EN
        if (result < 0) result = '0;
`endif
    end

    always_comb begin
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
        out_if.out_valid = (state_q == EMIT);
        out_if.out_data  = (state_q == EMIT) ? result : '0;
        out_if.out_row   = (state_q == EMIT) ? row_q  : '0;
    end

endmodule
